// File: rtl/boundary_slot_scheduler_if.sv
// Requester-side and boundary-side signals of the boundary slot scheduler.
// slave is the scheduler's view; master is the requester/boundary environment view.
interface boundary_slot_scheduler_if #(
  parameter int N      = 4,
  parameter int FLIT_W = 144
);
  logic [N-1:0]        req_valid;
  logic [N*FLIT_W-1:0] req_flit;
  logic [N-1:0]        req_ready;
  logic                bnd_stall;
  logic [FLIT_W-1:0]   bnd_flit;
  logic                bnd_valid;
  logic                bnd_slot;
  logic                bnd_fire;

  modport master (
    output req_valid, req_flit, bnd_stall,
    input  req_ready, bnd_flit, bnd_valid, bnd_slot, bnd_fire
  );

  modport slave (
    input  req_valid, req_flit, bnd_stall,
    output req_ready, bnd_flit, bnd_valid, bnd_slot, bnd_fire
  );
endinterface

// File: rtl/boundary_slot_scheduler.sv
// Round-robin + starvation-override arbiter feeding a 1-entry holding register that drains
// only on boundary slot cycles; grant-to-valid is 1 cycle, stall holds the flit and blocks grants.
module boundary_slot_scheduler #(
  parameter int N          = 4,
  parameter int FLIT_W     = 144,
  parameter int RATIO      = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  boundary_slot_scheduler_if.slave bus
);
  localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [SW-1:0]     starve_q [N];
  logic [FLIT_W-1:0] hold_q;
  logic [FLIT_W-1:0] flits [N];

  logic          slot, fire, can_load, grant_any;
  logic          starved_found, rr_found;
  logic [IW-1:0] starved_idx, rr_idx, rr_probe, winner, rr_next;
  logic [N-1:0]  grant;
  int            rr_j;

  assign slot      = (phase_q == PW'(RATIO - 1));
  assign fire      = (state_q == FULL) && slot && !bus.bnd_stall;
  assign can_load  = (state_q == EMPTY) || fire;
  assign grant_any = can_load && (|bus.req_valid);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      flits[i] = bus.req_flit[i*FLIT_W +: FLIT_W];
    end
  end

  // Starved requesters pre-empt round-robin; the lowest starved index wins.
  always_comb begin
    starved_found = 1'b0;
    starved_idx   = '0;
    rr_found      = 1'b0;
    rr_idx        = '0;
    rr_probe      = '0;
    rr_j          = 0;
    for (int i = 0; i < N; i++) begin
      if (!starved_found && bus.req_valid[i] && (starve_q[i] >= SW'(STARVE_LIM))) begin
        starved_found = 1'b1;
        starved_idx   = IW'(i);
      end
    end
    for (int k = 0; k < N; k++) begin
      rr_j     = (int'(rr_ptr_q) + k) % N;
      rr_probe = IW'(rr_j);
      if (!rr_found && bus.req_valid[rr_probe]) begin
        rr_found = 1'b1;
        rr_idx   = rr_probe;
      end
    end
  end

  assign winner  = starved_found ? starved_idx : rr_idx;
  assign rr_next = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
  assign grant   = grant_any ? (N'(1) << winner) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant_any) state_d = FULL;
      FULL:    if (fire && !grant_any) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      phase_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      for (int i = 0; i < N; i++) starve_q[i] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= slot ? '0 : phase_q + 1'b1;
      if (grant_any) begin
        hold_q   <= flits[winner];
        rr_ptr_q <= rr_next;
      end
      // Only slots actually spent on someone else count against a waiting requester.
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || grant[i]) begin
          starve_q[i] <= '0;
        end else if (fire && (starve_q[i] < SW'(STARVE_LIM))) begin
          starve_q[i] <= starve_q[i] + 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.bnd_flit  = hold_q;
  assign bus.bnd_valid = (state_q == FULL);
  assign bus.bnd_slot  = slot;
  assign bus.bnd_fire  = fire;
endmodule

// File: tb/tb_boundary_slot_scheduler.sv
// Directed bench: instance a runs RATIO=4/STARVE_LIM=3, instance b runs RATIO=1/STARVE_LIM=1.
module tb_boundary_slot_scheduler;
  localparam int FW = 144;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  boundary_slot_scheduler_if #(.N(4), .FLIT_W(FW)) a_if ();
  boundary_slot_scheduler_if #(.N(4), .FLIT_W(FW)) b_if ();

  boundary_slot_scheduler #(.N(4), .FLIT_W(FW), .RATIO(4), .STARVE_LIM(3)) dut_a (
    .clk(clk), .rst(rst_a), .bus(a_if.slave)
  );
  boundary_slot_scheduler #(.N(4), .FLIT_W(FW), .RATIO(1), .STARVE_LIM(1)) dut_b (
    .clk(clk), .rst(rst_b), .bus(b_if.slave)
  );

  task automatic check(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mkflit(input int i);
    logic [FW-1:0] f;
    f = 144'h0123456789abcdef0123456789abcdef1851;
    if (i != 0) begin
      f = ~f;
      f[7:0] = 8'(i);
    end
    return f;
  endfunction

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic reset_a();
    a_if.req_valid = '0;
    a_if.bnd_stall = 1'b0;
    @(posedge clk);
    #1 rst_a = 1'b1;
    #1 rst_a = 1'b0;
  endtask

  task automatic reset_b();
    b_if.req_valid = '0;
    b_if.bnd_stall = 1'b0;
    @(posedge clk);
    #1 rst_b = 1'b1;
    #1 rst_b = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    int lost;
    int g3_cyc;

    a_if.req_valid = '0;
    a_if.bnd_stall = 1'b0;
    a_if.req_flit  = {mkflit(3), mkflit(2), mkflit(1), mkflit(0)};
    b_if.req_valid = '0;
    b_if.bnd_stall = 1'b0;
    b_if.req_flit  = {mkflit(3), mkflit(2), mkflit(1), mkflit(0)};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", FW'(a_if.bnd_valid), FW'(0));
    check("rst_flit",  a_if.bnd_flit, '0);
    check("rst_ready", FW'(a_if.req_ready), FW'(0));
    check("rst_slot",  FW'(a_if.bnd_slot), FW'(0));
    check("rst_fire",  FW'(a_if.bnd_fire), FW'(0));
    rst_b = 1'b0;

    // 1: single flit, grant c0, valid c1, fire c3
    reset_a();
    a_if.req_valid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t1_ready", FW'(a_if.req_ready), FW'(c == 0 ? 4'b0001 : 4'b0000));
      check("t1_valid", FW'(a_if.bnd_valid), FW'(c >= 1));
      check("t1_fire",  FW'(a_if.bnd_fire),  FW'(c == 3));
      if (c == 3) check("t1_flit", a_if.bnd_flit, mkflit(0));
      next_cycle();
      a_if.req_valid = '0;
    end

    // 2: all valid, grants 0,1,2,3,0, fire every 4th cycle with no gaps
    reset_a();
    a_if.req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_rdy = (c == 0) ? oh(0) : ((c % 4 == 3) ? oh(((c + 1) / 4) % 4) : 4'b0000);
      check("t2_ready", FW'(a_if.req_ready), FW'(exp_rdy));
      check("t2_fire",  FW'(a_if.bnd_fire),  FW'(c % 4 == 3));
      if (c % 4 == 3) check("t2_flit", a_if.bnd_flit, mkflit(((c - 3) / 4) % 4));
      next_cycle();
    end

    // 3: stall two slots, fire on the third, flit held unchanged
    reset_a();
    a_if.req_valid = 4'b0101;
    for (int c = 0; c < 12; c++) begin
      a_if.bnd_stall = (c >= 1 && c <= 10);
      @(negedge clk);
      exp_rdy = (c == 0) ? 4'b0001 : ((c == 11) ? 4'b0100 : 4'b0000);
      check("t3_ready", FW'(a_if.req_ready), FW'(exp_rdy));
      check("t3_fire",  FW'(a_if.bnd_fire),  FW'(c == 11));
      if (c >= 1) check("t3_flit", a_if.bnd_flit, mkflit(0));
      next_cycle();
    end
    a_if.bnd_stall = 1'b0;

    // 4: requester 3 joins behind 0-2 and must win within 3 lost slots
    reset_a();
    a_if.req_valid = 4'b0111;
    lost   = 0;
    g3_cyc = -1;
    for (int c = 0; c < 16; c++) begin
      if (c == 1) a_if.req_valid = 4'b1111;
      @(negedge clk);
      if (g3_cyc < 0) begin
        if (a_if.req_ready == 4'b1000) g3_cyc = c;
        else if (a_if.bnd_fire && a_if.req_valid[3]) lost++;
      end
      next_cycle();
    end
    check("t4_grant3_cycle", FW'(g3_cyc), FW'(11));
    check("t4_lost_slots",   FW'(lost),   FW'(2));

    // 5: reset while FULL at phase 2 discards the flit
    reset_a();
    a_if.req_valid = 4'b0001;
    next_cycle();
    a_if.req_valid = '0;
    next_cycle();
    check("t5_full_before", FW'(a_if.bnd_valid), FW'(1));
    #1 rst_a = 1'b1;
    #1;
    check("t5_valid_async", FW'(a_if.bnd_valid), FW'(0));
    check("t5_slot_async",  FW'(a_if.bnd_slot),  FW'(0));
    rst_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_fire",  FW'(a_if.bnd_fire),  FW'(0));
      check("t5_valid", FW'(a_if.bnd_valid), FW'(0));
      check("t5_slot",  FW'(a_if.bnd_slot),  FW'(c == 3));
      next_cycle();
    end

    // 6: RATIO=1, requesters 1 and 2 alternate with a fire every cycle
    reset_b();
    b_if.req_valid = 4'b0110;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("t6_ready", FW'(b_if.req_ready), FW'(c % 2 == 0 ? oh(1) : oh(2)));
      check("t6_fire",  FW'(b_if.bnd_fire),  FW'(c >= 1));
      if (c >= 1) check("t6_flit", b_if.bnd_flit, (c % 2 == 1) ? mkflit(1) : mkflit(2));
      next_cycle();
    end

    // Starvation override beats round-robin when STARVE_LIM=1: 0,1,0,1 instead of 0,1,2,3
    reset_b();
    b_if.req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("ovr_ready", FW'(b_if.req_ready), FW'(c % 2 == 0 ? oh(0) : oh(1)));
      next_cycle();
    end
    b_if.req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
